query_patch_reader: RTL and testbench

Streams stored query patches out of the query patch memory's read port (port 1) to the compute pipeline over a valid/ready interface. It is the read-side counterpart of the I/O path that fills the memory. The block accounts for the 1-cycle SRAM read latency and absorbs downstream backpressure with a 2-entry output FIFO. Given a start address and a patch count, it issues sequential reads, wraps modulo DEPTH, and pulses done after the last patch is accepted.

---
 rtl/query_patch_reader.sv | 140 ++++++++++++++
 tb/tb_query_patch_reader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/query_patch_reader.sv
// Streams a burst of stored query patches from the memory read port to a
// valid/ready consumer, hiding the 1-cycle read latency behind a 2-entry FIFO.
module query_patch_reader #(
   parameter int unsigned DATA_WIDTH = 11,
   parameter int unsigned PATCH_SIZE = 5,
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned DEPTH      = 512
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [ADDR_WIDTH-1:0]            start_addr,
   input  logic [ADDR_WIDTH:0]              num_patches,
   output logic                             busy,
   output logic                             done,
   output logic                             csb1,
   output logic [ADDR_WIDTH-1:0]            addr1,
   input  logic [DATA_WIDTH*PATCH_SIZE-1:0] rpatch1,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_WIDTH*PATCH_SIZE-1:0] out_patch,
   output logic [ADDR_WIDTH:0]              out_idx
);

   localparam int unsigned PW = DATA_WIDTH * PATCH_SIZE;
   localparam int unsigned CW = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [CW-1:0] idx;
      logic [PW-1:0] patch;
   } entry_t;

   state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CW-1:0]   num_q;
   logic [CW-1:0]   issued_q;
   logic            inflight_q;
   logic [CW-1:0]   inflight_idx_q;
   entry_t          slot0_q, slot1_q;
   logic            slot0_vld_q, slot1_vld_q;
   logic            busy_q, done_q;

   logic            pop;
   logic            issue;
   logic            last_pop;
   logic [1:0]      fifo_cnt;
   logic [2:0]      occ;
   logic [CW-1:0]   num_clamped;
   entry_t          push_entry;

   assign pop         = slot0_vld_q & out_ready;
   assign fifo_cnt    = 2'(slot0_vld_q) + 2'(slot1_vld_q);
   // Slots committed for the next edge: buffered + in flight, minus the one leaving now.
   assign occ         = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);
   assign issue       = (state_q == RUN) && (issued_q != num_q) && (occ < 3'd2);
   assign last_pop    = pop && (slot0_q.idx == num_q - CW'(1));
   assign num_clamped = (num_patches > CW'(DEPTH)) ? CW'(DEPTH) : num_patches;
   assign push_entry  = '{idx: inflight_idx_q, patch: rpatch1};

   // Read strobe follows the same-cycle pop so the FIFO can refill at full rate.
   assign csb1      = ~issue;
   assign addr1     = addr_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign out_valid = slot0_vld_q;
   assign out_patch = slot0_q.patch;
   assign out_idx   = slot0_q.idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (num_clamped == '0) ? DONE : RUN;
         RUN:     if (issue && (issued_q + CW'(1) == num_q)) state_d = DRAIN;
         DRAIN:   if (last_pop) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Burst bookkeeping and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q         <= '0;
         num_q          <= '0;
         issued_q       <= '0;
         inflight_q     <= 1'b0;
         inflight_idx_q <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         if (state_q == IDLE && start) begin
            addr_q   <= start_addr;
            num_q    <= num_clamped;
            issued_q <= '0;
         end else if (issue) begin
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            issued_q <= issued_q + CW'(1);
         end
         inflight_q     <= issue;
         inflight_idx_q <= issued_q;
         busy_q         <= (state_d == RUN) || (state_d == DRAIN);
         done_q         <= (state_d == DONE);
      end
   end

   // Two-entry shift FIFO; slot0 is always the head
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0_q     <= '0;
         slot1_q     <= '0;
         slot0_vld_q <= 1'b0;
         slot1_vld_q <= 1'b0;
      end else if (pop) begin
         if (slot1_vld_q) begin
            slot0_q <= slot1_q;
            if (inflight_q) slot1_q     <= push_entry;
            else            slot1_vld_q <= 1'b0;
         end else begin
            if (inflight_q) slot0_q     <= push_entry;
            else            slot0_vld_q <= 1'b0;
         end
      end else if (inflight_q) begin
         if (!slot0_vld_q) begin
            slot0_q     <= push_entry;
            slot0_vld_q <= 1'b1;
         end else begin
            slot1_q     <= push_entry;
            slot1_vld_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_query_patch_reader.sv
// Self-checking bench for query_patch_reader: random memory contents and
// backpressure, checked against a per-burst ordinal model of reads and deliveries.
module tb_query_patch_reader;

   localparam int DW    = 11;
   localparam int PS    = 5;
   localparam int AW    = 9;
   localparam int DEPTH = 512;
   localparam int PW    = DW * PS;
   localparam int CW    = AW + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [CW-1:0] num_patches;
   logic          busy, done, csb1;
   logic [AW-1:0] addr1;
   logic [PW-1:0] rpatch1;
   logic          out_valid, out_ready;
   logic [PW-1:0] out_patch;
   logic [CW-1:0] out_idx;

   logic [PW-1:0] mem [DEPTH];
   int checks = 0;
   int errors = 0;

   query_patch_reader #(.DATA_WIDTH(DW), .PATCH_SIZE(PS), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
      .num_patches(num_patches), .busy(busy), .done(done), .csb1(csb1),
      .addr1(addr1), .rpatch1(rpatch1), .out_valid(out_valid),
      .out_ready(out_ready), .out_patch(out_patch), .out_idx(out_idx)
   );

   always #5 clk = ~clk;

   // SRAM model: data one cycle after a read, junk otherwise
   always @(posedge clk) begin
      if (!csb1) rpatch1 <= mem[addr1];
      else       rpatch1 <= PW'({$urandom(), $urandom()});
   end

   function automatic logic ready_of(input int mode, input int c);
      case (mode)
         0:       return 1'b1;
         1:       return ((c % 4) == 0) || ((c % 4) == 3);
         default: return ($urandom % 3) != 0;
      endcase
   endfunction

   task automatic burst(input int sa, input int n, input int mode, input bit hold);
      int ne, issued, popped, last_hs, done_cyc, budget, pop_now;
      int issue_cyc[$];
      bit exp_valid, exp_low, exp_done, exp_busy;
      logic [PW-1:0] exp_patch;
      ne = (n > DEPTH) ? DEPTH : n;
      issued = 0; popped = 0; last_hs = -1; done_cyc = -1;
      budget = ne * 8 + 30;
      @(posedge clk); #1;
      start = 1'b1; start_addr = AW'(sa); num_patches = CW'(n); out_ready = ready_of(mode, 0);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || csb1 !== 1'b1)
         $display("FAIL idle_before_start: busy=%b done=%b csb1=%b, want 0 0 1", busy, done, csb1);
      for (int c = 1; c <= budget; c++) begin
         @(posedge clk); #1;
         if (!hold || done_cyc >= 0) start = 1'b0;
         out_ready = ready_of(mode, c);
         @(negedge clk);
         pop_now = (out_valid && out_ready) ? 1 : 0;
         // Read issue: allowed iff committed slots stay below two
         exp_low = (issued < ne) && ((issued - popped - pop_now) < 2);
         checks++;
         if (csb1 !== !exp_low) begin
            errors++;
            $display("FAIL read_issue c=%0d: csb1=%b want %b (issued=%0d popped=%0d)", c, csb1, !exp_low, issued, popped);
         end
         if (exp_low && !csb1) begin
            checks++;
            if (addr1 !== AW'((sa + issued) % DEPTH)) begin
               errors++;
               $display("FAIL read_addr ord=%0d: addr1=%0d want %0d", issued, addr1, (sa + issued) % DEPTH);
            end
         end
         // Output head: oldest read at least two cycles old and not yet taken
         exp_valid = (popped < issue_cyc.size()) && (issue_cyc[popped] <= c - 2);
         checks++;
         if (out_valid !== exp_valid) begin
            errors++;
            $display("FAIL out_valid c=%0d: got %b want %b", c, out_valid, exp_valid);
         end
         if (exp_valid && out_valid) begin
            exp_patch = mem[(sa + popped) % DEPTH];
            checks++;
            if (out_idx !== CW'(popped) || out_patch !== exp_patch) begin
               errors++;
               $display("FAIL out_data c=%0d: idx=%0d patch=%h want idx=%0d patch=%h", c, out_idx, out_patch, popped, exp_patch);
            end
            if (pop_now != 0) begin
               popped++;
               if (popped == ne) last_hs = c;
            end
         end
         if (exp_low && !csb1) begin
            issue_cyc.push_back(c);
            issued++;
         end
         exp_done = (ne == 0) ? (c == 1) : (last_hs >= 0 && c == last_hs + 1);
         exp_busy = (ne > 0) && (last_hs < 0 || c <= last_hs);
         checks++;
         if (busy !== exp_busy || done !== exp_done) begin
            errors++;
            $display("FAIL status c=%0d: busy=%b done=%b want %b %b", c, busy, done, exp_busy, exp_done);
         end
         if (exp_done && done_cyc < 0) done_cyc = c;
         if (done_cyc >= 0 && c == done_cyc + 2) break;
      end
      checks++;
      if (done_cyc < 0 || issued != ne || popped != ne) begin
         errors++;
         $display("FAIL burst_end n=%0d: done_seen=%0d reads=%0d delivered=%0d want %0d", n, done_cyc >= 0, issued, popped, ne);
      end
      start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || csb1 !== 1'b1 || addr1 !== '0 ||
          out_valid !== 1'b0 || out_patch !== '0 || out_idx !== '0) begin
         errors++;
         $display("FAIL %s: busy=%b done=%b csb1=%b addr1=%0d valid=%b patch=%h idx=%0d, want reset values",
                  tag, busy, done, csb1, addr1, out_valid, out_patch, out_idx);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start_addr = '0; num_patches = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset_state");
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk) check_reset_outputs("after_release");
   endtask

   task automatic test_basic();
      for (int i = 0; i < 4; i++) mem[i] = PW'(100 + i);
      burst(0, 4, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      burst(int'($urandom_range(0, DEPTH - 1)), 8, 1, 1'b0);
   endtask

   task automatic test_wrap();
      burst(510, 4, 2, 1'b0);
   endtask

   task automatic test_zero_and_clamp();
      burst(37, 0, 0, 1'b0);
      burst(int'($urandom_range(0, DEPTH - 1)), 600, 2, 1'b0);
      burst(5, 512, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      int got;
      got = 0;
      @(posedge clk); #1;
      start = 1'b1; start_addr = AW'(200); num_patches = CW'(10); out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 0; c < 40 && got < 3; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) got++;
      end
      checks++;
      if (got != 3) begin
         errors++;
         $display("FAIL reset_mid_progress: delivered %0d want 3", got);
      end
      @(posedge clk); #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset_mid_immediate");
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("reset_mid_held");
      @(negedge clk) rst_n = 1'b1;
      burst(0, 2, 0, 1'b0);
   endtask

   task automatic test_start_held();
      burst(int'($urandom_range(0, DEPTH - 1)), 6, 1, 1'b1);
      burst(int'($urandom_range(0, DEPTH - 1)), 3, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int b = 0; b < 10; b++)
         burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), int'($urandom_range(0, 2)), 1'b0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = PW'({$urandom(), $urandom()});
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero_and_clamp();
      test_reset_mid();
      test_start_held();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
